// File: rtl/tlb_pkg.sv
// Shared TLB definitions: geometry, packed entry layout and CP0 TLB op codes.
// The TLB array, CP0 and the op sequencer all use these, so entry field
// offsets live in exactly one place.
package tlb_pkg;

    localparam int NUM_ENTRIES = 16;
    localparam int IDX_W       = 4;
    localparam int VPN2_W      = 19;
    localparam int PFN_W       = 24;
    localparam int ENTRY_W     = 71;

    // Bit position of the vpn2 field inside a packed entry (top of the word).
    localparam int VPN2_LSB    = ENTRY_W - VPN2_W;

    // Highest TLB index; Random reloads to this value.
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_ENTRIES - 1);

    typedef enum logic [1:0] {
        TLBP  = 2'b00,
        TLBR  = 2'b01,
        TLBWI = 2'b10,
        TLBWR = 2'b11
    } tlb_op_e;

    // Field order matches the EntryHi/EntryLo1/EntryLo0 image from CP0:
    // {vpn2[70:52], pfn1[51:28], d1[27], v1[26], pfn0[25:2], d0[1], v0[0]}
    typedef struct packed {
        logic [VPN2_W-1:0] vpn2;
        logic [PFN_W-1:0]  pfn1;
        logic              d1;
        logic              v1;
        logic [PFN_W-1:0]  pfn0;
        logic              d0;
        logic              v0;
    } tlb_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PROBE = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/tlb_random_counter.sv
// MIPS Random register. Counts down once per clock and reloads to the top
// index when it reaches (or sits below) Wired, so TLBWR never touches the
// wired entries. A write to Wired also reloads it.
module tlb_random_counter
    import tlb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] cp0_wired,
    input  logic             wired_we,
    output logic [IDX_W-1:0] random
);

    logic [IDX_W-1:0] random_reg;
    logic [IDX_W-1:0] random_next;

    // Next value: Wired write has priority, then wrap at/below Wired, else count down.
    always_comb begin
        random_next = random_reg - IDX_W'(1);
        if (wired_we) begin
            random_next = IDX_MAX;
        end else if (random_reg <= cp0_wired) begin
            random_next = IDX_MAX;
        end
    end

    // Random register; comes out of reset at the top index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            random_reg <= IDX_MAX;
        end else begin
            random_reg <= random_next;
        end
    end

    assign random = random_reg;

endmodule

// File: rtl/tlb_op_sequencer.sv
// Sequences CP0 TLB instructions (TLBP, TLBR, TLBWI, TLBWR) against the TLB
// array. Owns the array's only write port and one combinational read port.
// TLBP walks the array one entry per cycle with a single comparator; the
// lowest matching index wins and valid bits are not considered.
// Operands are captured on accept so CP0 may change underneath an op.
module tlb_op_sequencer
    import tlb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               op_valid,
    input  logic [1:0]         op_code,
    output logic               op_ready,
    input  logic               flush,
    input  logic [ENTRY_W-1:0] cp0_entry,
    input  logic [IDX_W-1:0]   cp0_index,
    input  logic [IDX_W-1:0]   cp0_wired,
    input  logic               wired_we,
    output logic [IDX_W-1:0]   rd_idx,
    input  logic [ENTRY_W-1:0] rd_entry,
    output logic               wr_en,
    output logic [IDX_W-1:0]   wr_idx,
    output logic [ENTRY_W-1:0] wr_entry,
    output logic               done,
    output logic               probe_hit,
    output logic [IDX_W-1:0]   probe_index,
    output logic [ENTRY_W-1:0] read_entry,
    output logic [IDX_W-1:0]   random
);

    seq_state_e        state_reg, state_next;
    logic [IDX_W-1:0]  scan_ptr_reg, scan_ptr_next;
    logic [IDX_W-1:0]  target_reg, target_next;
    logic [VPN2_W-1:0] key_reg, key_next;
    logic              probe_hit_reg, probe_hit_next;
    logic [IDX_W-1:0]  probe_index_reg, probe_index_next;
    logic [IDX_W-1:0]  wr_idx_reg, wr_idx_next;
    tlb_entry_t        wr_entry_reg, wr_entry_next;
    tlb_entry_t        read_entry_reg, read_entry_next;

    tlb_op_e           op;
    logic [IDX_W-1:0]  accept_target;
    logic [VPN2_W-1:0] rd_vpn2;

    tlb_random_counter u_random (
        .clk       (clk),
        .rst_n     (rst_n),
        .cp0_wired (cp0_wired),
        .wired_we  (wired_we),
        .random    (random)
    );

    assign op            = tlb_op_e'(op_code);
    // TLBWR targets whatever Random holds in the accept cycle.
    assign accept_target = (op == TLBWR) ? random : cp0_index;
    assign rd_vpn2       = rd_entry[ENTRY_W-1:VPN2_LSB];

    // Next-state, operand capture and the unregistered strobes (ready, rd_idx,
    // wr_en, done). Flush returns to IDLE from any busy state and leaves the
    // held probe/read results untouched.
    always_comb begin
        state_next       = state_reg;
        scan_ptr_next    = scan_ptr_reg;
        target_next      = target_reg;
        key_next         = key_reg;
        probe_hit_next   = probe_hit_reg;
        probe_index_next = probe_index_reg;
        wr_idx_next      = wr_idx_reg;
        wr_entry_next    = wr_entry_reg;
        read_entry_next  = read_entry_reg;
        op_ready         = 1'b0;
        rd_idx           = '0;
        wr_en            = 1'b0;
        done             = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (op_valid && !flush) begin
                    target_next   = accept_target;
                    key_next      = cp0_entry[ENTRY_W-1:VPN2_LSB];
                    scan_ptr_next = '0;
                    case (op)
                        TLBP:    state_next = ST_PROBE;
                        TLBR:    state_next = ST_READ;
                        default: begin
                            // The op itself is carried by the state; only write
                            // operands need to survive into WRITE.
                            state_next    = ST_WRITE;
                            wr_idx_next   = accept_target;
                            wr_entry_next = tlb_entry_t'(cp0_entry);
                        end
                    endcase
                end
            end

            ST_PROBE: begin
                rd_idx = scan_ptr_reg;
                if (flush) begin
                    state_next = ST_IDLE;
                end else if (rd_vpn2 == key_reg) begin
                    probe_hit_next   = 1'b1;
                    probe_index_next = scan_ptr_reg;
                    state_next       = ST_DONE;
                end else if (scan_ptr_reg == IDX_MAX) begin
                    probe_hit_next   = 1'b0;
                    probe_index_next = '0;
                    state_next       = ST_DONE;
                end else begin
                    scan_ptr_next = scan_ptr_reg + IDX_W'(1);
                end
            end

            ST_READ: begin
                rd_idx = target_reg;
                if (flush) begin
                    state_next = ST_IDLE;
                end else begin
                    read_entry_next = tlb_entry_t'(rd_entry);
                    state_next      = ST_DONE;
                end
            end

            ST_WRITE: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else begin
                    wr_en      = 1'b1;
                    state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                done       = !flush;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and operand/result registers; reset discards any pending op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            scan_ptr_reg    <= '0;
            target_reg      <= '0;
            key_reg         <= '0;
            probe_hit_reg   <= 1'b0;
            probe_index_reg <= '0;
            wr_idx_reg      <= '0;
            wr_entry_reg    <= '0;
            read_entry_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            scan_ptr_reg    <= scan_ptr_next;
            target_reg      <= target_next;
            key_reg         <= key_next;
            probe_hit_reg   <= probe_hit_next;
            probe_index_reg <= probe_index_next;
            wr_idx_reg      <= wr_idx_next;
            wr_entry_reg    <= wr_entry_next;
            read_entry_reg  <= read_entry_next;
        end
    end

    assign probe_hit   = probe_hit_reg;
    assign probe_index = probe_index_reg;
    assign wr_idx      = wr_idx_reg;
    assign wr_entry    = wr_entry_reg;
    assign read_entry  = read_entry_reg;

endmodule
